// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access path: geometry of the
// 24-bit-word byte memory and the arbiter sequencing states.
package dm_pkg;

    localparam int DM_AW         = 24;
    localparam int DM_DW         = 24;
    localparam int DM_MEM_BYTES  = 256;
    localparam int DM_WORD_BYTES = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dm_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way request picker: fixed priority to port 0, or alternate away
// from the port that was served last when both ask at once.
module rr_pick2
    import dm_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_gnt_id,
    output logic o_valid
);

    // Choose the winning port; a lone requester always wins.
    always_comb begin
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_gnt_id = (FIXED_PRIO != 0) ? 1'b0 : ~i_last_grant;
        end else begin
            o_gnt_id = i_req1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter and access sequencer for the 24-bit-word data memory.
// Each transaction runs IDLE (grant) -> ACCESS (memory cycle) -> RESP (ack).
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int AW         = DM_AW,
    parameter int DW         = DM_DW,
    parameter int MEM_BYTES  = DM_MEM_BYTES,
    parameter int WORD_BYTES = DM_WORD_BYTES,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          busy,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_din,
    output logic          mem_wen,
    input  logic [DW-1:0] mem_dout
);

    // Highest word start address whose three bytes all fit in memory.
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_BYTES - WORD_BYTES);

    dm_state_t     r_state;
    dm_state_t     w_next;
    logic          r_gnt_id;
    logic          r_we;
    logic          r_range_err;
    logic          r_last_grant;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_mem_add;
    logic [DW-1:0] r_mem_din;

    logic          w_gnt_id;
    logic          w_valid;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_last_grant (r_last_grant),
        .o_gnt_id     (w_gnt_id),
        .o_valid      (w_valid)
    );

    assign w_sel_we    = w_gnt_id ? we1    : we0;
    assign w_sel_addr  = w_gnt_id ? addr1  : addr0;
    assign w_sel_wdata = w_gnt_id ? wdata1 : wdata0;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: a grant starts a fixed three-cycle sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Transaction registers: latch the request on grant, read data in ACCESS,
    // remember the served port in RESP so round-robin favours the other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_id     <= 1'b0;
            r_we         <= 1'b0;
            r_range_err  <= 1'b0;
            r_last_grant <= 1'b1;
            r_rdata      <= '0;
            r_mem_add    <= '0;
            r_mem_din    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gnt_id    <= w_gnt_id;
                        r_we        <= w_sel_we;
                        r_mem_add   <= w_sel_addr;
                        r_mem_din   <= w_sel_wdata;
                        r_range_err <= (w_sel_addr > LAST_ADDR);
                    end
                end
                ACCESS: begin
                    r_rdata <= (r_we || r_range_err) ? '0 : mem_dout;
                end
                RESP: begin
                    r_last_grant <= r_gnt_id;
                end
                default: ;
            endcase
        end
    end

    // Outputs: write strobe only in ACCESS, response steered to the granted port.
    always_comb begin
        busy    = (r_state != IDLE);
        mem_add = r_mem_add;
        mem_din = r_mem_din;
        mem_wen = (r_state == ACCESS) && r_we && !r_range_err;
        ack0    = 1'b0;
        ack1    = 1'b0;
        rdata0  = '0;
        rdata1  = '0;
        err0    = 1'b0;
        err1    = 1'b0;
        if (r_state == RESP) begin
            if (r_gnt_id) begin
                ack1   = 1'b1;
                rdata1 = r_rdata;
                err1   = r_range_err;
            end else begin
                ack0   = 1'b1;
                rdata0 = r_rdata;
                err0   = r_range_err;
            end
        end
    end

endmodule
